// File: rtl/uart_receiver_if.sv
// uart_receiver_if: serial line, matrix read port and receive status of the UART receiver
interface uart_receiver_if #(parameter int W = 8);
  logic rx;
  logic row;
  logic [1:0] col;
  logic clr;
  logic [W-1:0] r_cell;
  logic [W-1:0] rx_data;
  logic rx_valid;
  logic parity_err;
  logic frame_err;
  logic busy;
  logic [2:0] wr_ptr;
  modport master (
    output rx, row, col, clr,
    input r_cell, rx_data, rx_valid, parity_err, frame_err, busy, wr_ptr
  );
  modport slave (
    input rx, row, col, clr,
    output r_cell, rx_data, rx_valid, parity_err, frame_err, busy, wr_ptr
  );
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: deserialises UART frames and stores good words in a 2x4 matrix
module uart_receiver #(
  parameter int W = 8,
  parameter int DIV = 3,
  parameter int PAR = 0
) (
  input logic clk,
  input logic rst,
  uart_receiver_if.slave bus
);
  localparam int H = DIV / 2;
  localparam int P = (PAR != 0) ? 1 : 0;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(W + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
  state_t state, state_n;
  logic [1:0] sync;
  logic rx_s;
  logic [CW-1:0] tick, tick_n;
  logic [BW-1:0] bit_cnt, bit_cnt_n;
  logic [W-1:0] shreg, shreg_n;
  logic par_acc, par_acc_n;
  logic bad_par, bad_par_n;
  logic done;
  logic fin_valid, fin_perr, fin_ferr;
  logic [W-1:0] mem [2][4];
  logic [2:0] ptr;
  logic [W-1:0] data_q;
  logic valid_q, perr_q, ferr_q;
  // two-flop synchroniser for the asynchronous serial line, idle high
  always_ff @(posedge clk)
    sync <= rst ? 2'b11 : {sync[0], bus.rx};
  assign rx_s = sync[1];
  // frame state register and shift datapath
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      tick <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      par_acc <= 1'b0;
      bad_par <= 1'b0;
    end else begin
      state <= state_n;
      tick <= tick_n;
      bit_cnt <= bit_cnt_n;
      shreg <= shreg_n;
      par_acc <= par_acc_n;
      bad_par <= bad_par_n;
    end
  // next state: tick counts down to the next mid-bit sample point
  always_comb begin
    state_n = state;
    tick_n = tick - 1'b1;
    bit_cnt_n = bit_cnt;
    shreg_n = shreg;
    par_acc_n = par_acc;
    bad_par_n = bad_par;
    done = 1'b0;
    case (state)
      IDLE:
        if (!rx_s) begin
          state_n = (H == 0) ? DATA : START;
          tick_n = (H == 0) ? CW'(DIV - 1) : CW'(H - 1);
          bit_cnt_n = '0;
          par_acc_n = 1'b0;
          bad_par_n = 1'b0;
        end
      START:
        if (tick == '0) begin
          state_n = rx_s ? IDLE : DATA;
          tick_n = CW'(DIV - 1);
        end
      DATA:
        if (tick == '0) begin
          shreg_n = {rx_s, shreg[W-1:1]};
          par_acc_n = par_acc ^ rx_s;
          bit_cnt_n = bit_cnt + 1'b1;
          tick_n = CW'(DIV - 1);
          if (bit_cnt == BW'(W - 1))
            state_n = (P != 0) ? PARITY : STOP;
        end
      PARITY:
        if (tick == '0) begin
          bad_par_n = rx_s != ((PAR == 2) ? ~par_acc : par_acc);
          state_n = STOP;
          tick_n = CW'(DIV - 1);
        end
      STOP:
        if (tick == '0) begin
          done = 1'b1;
          state_n = rx_s ? IDLE : WAIT_HIGH;
        end
      WAIT_HIGH:
        if (rx_s)
          state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end
  assign fin_ferr = done & ~rx_s;
  assign fin_perr = done & rx_s & bad_par;
  assign fin_valid = done & rx_s & ~bad_par;
  // completion pulses and last word, framing error outranks parity
  always_ff @(posedge clk)
    if (rst) begin
      data_q <= '0;
      valid_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      valid_q <= fin_valid;
      perr_q <= fin_perr;
      ferr_q <= fin_ferr;
      if (done)
        data_q <= shreg;
    end
  // word matrix, clr beats a simultaneous store
  always_ff @(posedge clk)
    if (rst || bus.clr) begin
      mem <= '{default: '0};
      ptr <= '0;
    end else if (fin_valid) begin
      mem[ptr[2]][ptr[1:0]] <= shreg;
      ptr <= ptr + 1'b1;
    end
  assign bus.r_cell = mem[bus.row][bus.col];
  assign bus.rx_data = data_q;
  assign bus.rx_valid = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy = state != IDLE;
  assign bus.wr_ptr = ptr;
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: three receiver configurations checked against a frame-level event model
module tb_uart_receiver;
  localparam int W = 8;
  typedef struct {
    int cyc;
    int sel;
    int kind;
    logic [7:0] d;
  } ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxv [3];
  logic clrv [3];
  logic rd_row;
  logic [1:0] rd_col;
  logic [7:0] cell_a [3];
  logic [7:0] data_a [3];
  logic [2:0] ptr_a [3];
  logic valid_a [3];
  logic perr_a [3];
  logic ferr_a [3];
  logic busy_a [3];
  logic pbusy [3];
  int clr_at [3];
  logic [7:0] em [3][8];
  int eptr [3];
  ev_t got_q[$];
  ev_t exp_q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  always #10 clk = ~clk;
  uart_receiver_if #(.W(W)) ifs [3] ();
  // dut0: no parity DIV 3, dut1: even parity DIV 3, dut2: odd parity DIV 1
  for (genvar g = 0; g < 3; g++) begin : dut
    uart_receiver #(.W(W), .DIV(g == 2 ? 1 : 3), .PAR(g)) u (
      .clk(clk),
      .rst(rst),
      .bus(ifs[g])
    );
    assign ifs[g].rx = rxv[g];
    assign ifs[g].clr = clrv[g];
    assign ifs[g].row = rd_row;
    assign ifs[g].col = rd_col;
    assign cell_a[g] = ifs[g].r_cell;
    assign data_a[g] = ifs[g].rx_data;
    assign ptr_a[g] = ifs[g].wr_ptr;
    assign valid_a[g] = ifs[g].rx_valid;
    assign perr_a[g] = ifs[g].parity_err;
    assign ferr_a[g] = ifs[g].frame_err;
    assign busy_a[g] = ifs[g].busy;
  end
  function automatic int div_of(int s);
    return (s == 2) ? 1 : 3;
  endfunction
  function automatic ev_t mk(int c, int s, int k, logic [7:0] d);
    ev_t e;
    e.cyc = c;
    e.sel = s;
    e.kind = k;
    e.d = d;
    return e;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // one clock: drive clr, then log pulses (1 valid, 2 parity, 3 frame) and busy edges (4 rise, 5 fall)
  task automatic tick();
    for (int s = 0; s < 3; s++) clrv[s] = (cyc == clr_at[s]);
    @(negedge clk);
    cyc++;
    for (int s = 0; s < 3; s++) begin
      if (valid_a[s]) got_q.push_back(mk(cyc, s, 1, data_a[s]));
      if (perr_a[s]) got_q.push_back(mk(cyc, s, 2, data_a[s]));
      if (ferr_a[s]) got_q.push_back(mk(cyc, s, 3, data_a[s]));
      if (busy_a[s] !== pbusy[s]) got_q.push_back(mk(cyc, s, busy_a[s] ? 4 : 5, 8'h00));
      pbusy[s] = busy_a[s];
    end
  endtask
  task automatic drive(int s, logic b, int n);
    rxv[s] = b;
    repeat (n) tick();
  endtask
  task automatic clear_model(int s);
    for (int i = 0; i < 8; i++) em[s][i] = 8'h00;
    eptr[s] = 0;
  endtask
  // one frame; events are predicted from the frame timing, bit time dv, sample point dv/2
  task automatic send(int s, logic [7:0] d, bit bad_p, int stop_low, int gap, bit clr_hit);
    int dv, p, c0, ev;
    logic pb;
    dv = div_of(s);
    p = (s != 0) ? 1 : 0;
    c0 = cyc;
    pb = ((^d) ^ bad_p) ^ (s == 2);
    ev = c0 + 3 + dv / 2 + (W + 1 + p) * dv;
    exp_q.push_back(mk(c0 + 3, s, 4, 8'h00));
    if (stop_low > 0) begin
      exp_q.push_back(mk(ev, s, 3, d));
      exp_q.push_back(mk(c0 + (1 + W + p + stop_low) * dv + 3, s, 5, 8'h00));
    end else begin
      exp_q.push_back(mk(ev, s, (p == 1 && bad_p) ? 2 : 1, d));
      exp_q.push_back(mk(ev, s, 5, 8'h00));
      if (!(p == 1 && bad_p) && !clr_hit) begin
        em[s][eptr[s]] = d;
        eptr[s] = (eptr[s] + 1) % 8;
      end
    end
    if (clr_hit) begin
      clr_at[s] = ev - 1;
      clear_model(s);
    end
    drive(s, 1'b0, dv);
    for (int i = 0; i < W; i++) drive(s, d[i], dv);
    if (p == 1) drive(s, pb, dv);
    if (stop_low > 0) drive(s, 1'b0, stop_low * dv);
    drive(s, 1'b1, dv + gap);
  endtask
  task automatic flush();
    ev_t e, g;
    int i;
    repeat (8) tick();
    chk("event_count", got_q.size(), exp_q.size());
    i = 0;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      chk($sformatf("ev%0d_cyc", i), g.cyc, e.cyc);
      chk($sformatf("ev%0d_sel", i), g.sel, e.sel);
      chk($sformatf("ev%0d_kind", i), g.kind, e.kind);
      chk($sformatf("ev%0d_data", i), {24'h0, g.d}, {24'h0, e.d});
      i++;
    end
    exp_q.delete();
    got_q.delete();
  endtask
  task automatic check_state(int s);
    for (int i = 0; i < 8; i++) begin
      rd_row = i[2];
      rd_col = i[1:0];
      #1;
      chk($sformatf("cell%0d_%0d", s, i), {24'h0, cell_a[s]}, {24'h0, em[s][i]});
    end
    chk($sformatf("wr_ptr%0d", s), {29'h0, ptr_a[s]}, eptr[s]);
  endtask
  task automatic check_idle(int s, logic [7:0] d);
    chk($sformatf("rx_data%0d", s), {24'h0, data_a[s]}, {24'h0, d});
    chk($sformatf("rx_valid%0d", s), {31'h0, valid_a[s]}, 0);
    chk($sformatf("parity_err%0d", s), {31'h0, perr_a[s]}, 0);
    chk($sformatf("frame_err%0d", s), {31'h0, ferr_a[s]}, 0);
    chk($sformatf("busy%0d", s), {31'h0, busy_a[s]}, 0);
  endtask
  initial begin
    int r, c0;
    for (int s = 0; s < 3; s++) begin
      rxv[s] = 1'b1;
      clrv[s] = 1'b0;
      clr_at[s] = -1;
      pbusy[s] = 1'b0;
      clear_model(s);
    end
    rd_row = 1'b0;
    rd_col = 2'd0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    for (int s = 0; s < 3; s++) begin
      check_idle(s, 8'h00);
      check_state(s);
    end
    c0 = cyc;
    exp_q.push_back(mk(c0 + 3, 0, 4, 8'h00));
    exp_q.push_back(mk(c0 + 4, 0, 5, 8'h00));
    drive(0, 1'b0, 1);
    drive(0, 1'b1, 4);
    flush();
    check_state(0);
    send(0, 8'hA5, 1'b0, 0, 4, 1'b0);
    flush();
    check_state(0);
    check_idle(0, 8'hA5);
    send(1, 8'h03, 1'b1, 0, 4, 1'b0);
    flush();
    check_state(1);
    send(1, 8'h03, 1'b0, 0, 4, 1'b0);
    flush();
    check_state(1);
    send(2, 8'h81, 1'b0, 0, 2, 1'b0);
    send(2, 8'h80, 1'b1, 0, 2, 1'b0);
    flush();
    check_state(2);
    send(0, 8'h3C, 1'b0, 10, 4, 1'b0);
    flush();
    check_state(0);
    clr_at[0] = cyc;
    tick();
    clear_model(0);
    for (int i = 1; i <= 9; i++) send(0, i[7:0], 1'b0, 0, i % 3, 1'b0);
    flush();
    check_state(0);
    clr_at[0] = cyc;
    tick();
    clear_model(0);
    check_state(0);
    send(0, 8'h11, 1'b0, 0, 0, 1'b0);
    send(0, 8'h77, 1'b0, 0, 4, 1'b1);
    flush();
    check_state(0);
    send(0, 8'h22, 1'b0, 0, 4, 1'b0);
    flush();
    c0 = cyc;
    drive(0, 1'b0, 3);
    drive(0, 1'b1, 13);
    r = cyc;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    exp_q.push_back(mk(c0 + 3, 0, 4, 8'h00));
    exp_q.push_back(mk(r + 1, 0, 5, 8'h00));
    for (int s = 0; s < 3; s++) clear_model(s);
    flush();
    for (int s = 0; s < 3; s++) begin
      check_idle(s, 8'h00);
      check_state(s);
    end
    send(0, 8'h5A, 1'b0, 0, 4, 1'b0);
    flush();
    check_state(0);
    for (int k = 0; k < 40; k++) begin
      int s;
      s = $urandom_range(0, 2);
      send(s, 8'($urandom), (s != 0) && ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0,
           $urandom_range(0, 3), 1'b0);
    end
    flush();
    for (int s = 0; s < 3; s++) check_state(s);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
